// File: rtl/fpu_pkg.sv
// fpu_pkg: FPU op codes and op-class helpers shared by the FPU and its writeback stage
package fpu_pkg;
  localparam logic [3:0] FP_ADD = 4'd2;
  localparam logic [3:0] FP_SUB = 4'd4;
  localparam logic [3:0] FP_CEQ = 4'd8;
  localparam logic [3:0] FP_CLT = 4'd9;
  localparam logic [3:0] FP_CGT = 4'd10;
  localparam logic [3:0] FP_CGE = 4'd11;
  localparam logic [3:0] FP_CLE = 4'd13;
  function automatic logic is_arith(input logic [3:0] op);
    return op == FP_ADD || op == FP_SUB;
  endfunction
  function automatic logic is_cmp(input logic [3:0] op);
    return op == FP_CEQ || op == FP_CLT || op == FP_CGT || op == FP_CGE || op == FP_CLE;
  endfunction
endpackage

// File: rtl/fp_scoreboard.sv
// fp_scoreboard: pending-write tracking and RAW/WAW issue stall, with same-cycle writeback clear
module fp_scoreboard
  import fpu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [AW-1:0]    issue_dst,
  input  logic             wb_valid,
  input  logic [3:0]       wb_op,
  input  logic [AW-1:0]    wb_dst,
  output logic             issue_stall,
  output logic [NREGS-1:0] pending,
  output logic             fcc_pending
);
  logic [NREGS-1:0] wb_clr, eff, set;
  logic acc;
  always_comb begin
    wb_clr = (wb_valid && is_arith(wb_op)) ? NREGS'(1) << wb_dst : '0;
    eff = pending & ~wb_clr;
    issue_stall = issue_valid && (eff[rd_addr_a] || eff[rd_addr_b] || (is_arith(issue_op) && eff[issue_dst]));
    acc = issue_valid && !issue_stall;
    set = (acc && is_arith(issue_op)) ? NREGS'(1) << issue_dst : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      fcc_pending <= 1'b0;
    end else begin
      pending <= eff | set;
      fcc_pending <= (acc && is_cmp(issue_op)) || (fcc_pending && !(wb_valid && is_cmp(wb_op)));
    end
  end
endmodule

// File: rtl/fp_regfile_wb.sv
// fp_regfile_wb: FP register file with bypassed reads, writeback, condition flag and issue scoreboard
module fp_regfile_wb
  import fpu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [DW-1:0]    rd_data_a,
  output logic [DW-1:0]    rd_data_b,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [AW-1:0]    issue_dst,
  output logic             issue_stall,
  input  logic             wb_valid,
  input  logic [3:0]       wb_op,
  input  logic [AW-1:0]    wb_dst,
  input  logic [DW-1:0]    wb_data,
  output logic             fcc,
  output logic             fcc_valid,
  output logic [NREGS-1:0] pending
);
  logic [DW-1:0] regs [NREGS];
  logic wr, fcc_pending;
  always_comb begin
    wr = wb_valid && is_arith(wb_op);
    rd_data_a = (wr && wb_dst == rd_addr_a) ? wb_data : regs[rd_addr_a];
    rd_data_b = (wr && wb_dst == rd_addr_b) ? wb_data : regs[rd_addr_b];
    fcc_valid = !fcc_pending;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      fcc <= 1'b0;
    end else begin
      if (wr) regs[wb_dst] <= wb_data;
      if (wb_valid && is_cmp(wb_op)) fcc <= wb_data[0];
    end
  end
  fp_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_dst(issue_dst),
    .wb_valid(wb_valid), .wb_op(wb_op), .wb_dst(wb_dst),
    .issue_stall(issue_stall), .pending(pending), .fcc_pending(fcc_pending)
  );
endmodule

// File: tb/tb_fp_regfile_wb.sv
// tb_fp_regfile_wb: directed vectors with expectations queued per cycle and checked by a monitor
module tb_fp_regfile_wb;
  logic clk = 0, rst = 1;
  logic [4:0] rd_addr_a = 0, rd_addr_b = 0, issue_dst = 0, wb_dst = 0;
  logic [31:0] rd_data_a, rd_data_b, wb_data = 0, pending;
  logic issue_valid = 0, wb_valid = 0, issue_stall, fcc, fcc_valid;
  logic [3:0] issue_op = 0, wb_op = 0;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int cyc; int sig; logic [31:0] exp; string name;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] act;

  fp_regfile_wb dut (
    .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .issue_valid(issue_valid),
    .issue_op(issue_op), .issue_dst(issue_dst), .issue_stall(issue_stall),
    .wb_valid(wb_valid), .wb_op(wb_op), .wb_dst(wb_dst), .wb_data(wb_data),
    .fcc(fcc), .fcc_valid(fcc_valid), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int s);
    case (s)
      0: return rd_data_a;
      1: return rd_data_b;
      2: return 32'(issue_stall);
      3: return 32'(fcc);
      4: return 32'(fcc_valid);
      default: return pending;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      act = actual(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s (cycle %0d): got %h expected %h", e.name, e.cyc, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input int s, input logic [31:0] v, input string n);
    q.push_back('{cyc, s, v, n});
  endtask

  task automatic wb(input logic v, input logic [3:0] op, input logic [4:0] d, input logic [31:0] data);
    wb_valid = v; wb_op = op; wb_dst = d; wb_data = data;
  endtask

  task automatic iss(input logic v, input logic [3:0] op, input logic [4:0] d);
    issue_valid = v; issue_op = op; issue_dst = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) step();
    rst = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = 5'(a); rd_addr_b = 5'(31 - a);
      ex(0, 0, "reset_rd_a"); ex(1, 0, "reset_rd_b");
      if (a == 0) begin
        ex(3, 0, "reset_fcc"); ex(4, 1, "reset_fcc_valid");
        ex(5, 0, "reset_pending"); ex(2, 0, "reset_stall");
      end
      step();
    end
    // registers 31 and 0 are ordinary writable entries
    wb(1, 4, 31, 32'hC0000000); rd_addr_b = 31; ex(1, 32'hC0000000, "bypass_r31");
    step(); wb(1, 2, 0, 32'hA5A5A5A5); rd_addr_a = 31; ex(0, 32'hC0000000, "array_r31");
    step(); wb(0, 0, 0, 0); rd_addr_a = 0; ex(0, 32'hA5A5A5A5, "array_r0");
    step(); wb(1, 2, 5, 32'h40400000); rd_addr_a = 5; ex(0, 32'h40400000, "bypass_r5");
    step(); wb(0, 0, 0, 0); ex(0, 32'h40400000, "array_r5");
    step(); iss(1, 2, 3); rd_addr_a = 0; rd_addr_b = 0; ex(2, 0, "issue_add3");
    step(); iss(1, 2, 10); rd_addr_b = 3; ex(2, 1, "raw_stall_b"); ex(5, 32'h8, "pending_r3");
    step(); wb(1, 2, 3, 32'h3F800000); ex(2, 0, "raw_clear_same_cycle"); ex(1, 32'h3F800000, "bypass_r3");
    step(); wb(0, 0, 0, 0); iss(0, 0, 0); rd_addr_b = 0; ex(5, 32'h400, "pending_r10");
    step(); iss(1, 2, 12); rd_addr_a = 10; ex(2, 1, "raw_stall_a");
    step(); iss(0, 0, 0); rd_addr_a = 0; wb(1, 2, 10, 32'h41200000); ex(5, 32'h400, "pending_before_clear");
    step(); wb(0, 0, 0, 0); ex(5, 0, "pending_cleared");
    step(); iss(1, 9, 0); ex(2, 0, "issue_cmp");
    step(); iss(0, 0, 0); ex(4, 0, "fcc_valid_low"); ex(3, 0, "fcc_before");
    step(); wb(1, 9, 5, 32'h1); rd_addr_a = 5; ex(4, 0, "fcc_valid_during_wb"); ex(0, 32'h40400000, "cmp_no_bypass");
    step(); wb(0, 0, 0, 0); ex(3, 1, "fcc_set"); ex(4, 1, "fcc_valid_high"); ex(0, 32'h40400000, "cmp_no_write");
    step(); iss(1, 13, 0); rd_addr_a = 0;
    step(); iss(0, 0, 0); ex(4, 0, "fcc_valid_le"); wb(1, 13, 0, 32'hFFFFFFFE);
    step(); wb(0, 0, 0, 0); ex(3, 0, "fcc_clear_le"); ex(4, 1, "fcc_valid_le_done"); ex(0, 32'hA5A5A5A5, "cmp_le_no_write");
    step(); iss(1, 2, 7); ex(2, 0, "issue_add7");
    step(); iss(1, 4, 7); wb(1, 2, 7, 32'h11111111); ex(2, 0, "waw_cleared"); ex(5, 32'h80, "pending7_before");
    step(); iss(0, 0, 0); wb(0, 0, 0, 0); rd_addr_a = 7; ex(5, 32'h80, "set_wins"); ex(0, 32'h11111111, "array_r7");
    step(); iss(1, 2, 7); rd_addr_a = 0; ex(2, 1, "waw_stall");
    step(); iss(1, 0, 3); ex(2, 0, "op0_no_stall");
    step(); iss(0, 0, 0); wb(1, 0, 3, 32'hDEADBEEF); rd_addr_a = 3; ex(5, 32'h80, "op0_no_pending"); ex(0, 32'h3F800000, "op0_no_bypass");
    step(); wb(1, 12, 3, 32'hDEADBEEF); ex(0, 32'h3F800000, "op0_no_write"); ex(3, 0, "op0_fcc_kept");
    step(); wb(0, 0, 0, 0); ex(0, 32'h3F800000, "op12_no_write"); ex(3, 0, "op12_fcc_kept");
    step(); iss(1, 2, 3); rd_addr_a = 0; ex(2, 0, "issue_add3b");
    step(); iss(0, 0, 0); ex(5, 32'h88, "pending_88");
    step(); rst = 1; wb(1, 2, 12, 32'h12345678); iss(1, 2, 20);
    step(); rst = 0; wb(0, 0, 0, 0); iss(0, 0, 0); rd_addr_a = 12; rd_addr_b = 3;
    ex(5, 0, "rst_pending"); ex(0, 0, "rst_no_write"); ex(1, 0, "rst_regs_clear"); ex(3, 0, "rst_fcc"); ex(4, 1, "rst_fcc_valid");
    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_regfile_wb.md
# fp_regfile_wb

Floating-point register file and writeback stage for the FPU datapath. It supplies operands to the FPU `A`/`B` inputs and accepts FPU results. Arithmetic results are written to a 32×32 register file; compare results are written to a single condition flag (`fcc`). A pending-write scoreboard stalls issue on read-after-write and write-after-write hazards. Same-cycle writeback data is forwarded to the read ports.

## Interface
Parameters:
- `NREGS`, 32, number of FP registers
- `AW`, 5, register address width
- `DW`, 32, data width (IEEE-754 single)

Ports (one clock; reset is synchronous and active-high, `clk` / `rst`):
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `rd_addr_a`  in  AW  source register for FPU operand `A`
- `rd_addr_b`  in  AW  source register for FPU operand `B`
- `rd_data_a`  out  DW  operand `A` (combinational, bypassed)
- `rd_data_b`  out  DW  operand `B` (combinational, bypassed)
- `issue_valid`  in  1  instruction presented for issue to FPU
- `issue_op`  in  4  FPU op code of issuing instruction
- `issue_dst`  in  AW  destination register of issuing instruction
- `issue_stall`  out  1  issue must not proceed this cycle
- `wb_valid`  in  1  FPU result valid this cycle
- `wb_op`  in  4  op code of the result
- `wb_dst`  in  AW  destination register of the result
- `wb_data`  in  DW  FPU result
- `fcc`  out  1  FP condition flag
- `fcc_valid`  out  1  no compare outstanding; `fcc` usable by branches
- `pending`  out  NREGS  scoreboard bits, for debug and verification

## Operation
- Op classes:
  - arith = {2 add, 4 sub}
  - cmp = {8 eq, 9 lt, 10 gt, 11 ge, 13 le}
  - all other codes: no write, no `fcc` change, no scoreboard effect.
- Write: on `wb_valid` and arith, `regs[wb_dst] <= wb_data`. All registers are writable, including index 0.
- Compare: on `wb_valid` and cmp, `fcc <= wb_data[0]`, `fcc_pending <= 0`. The register file is unchanged.
- Read bypass: if `wb_valid`, arith, and `wb_dst == rd_addr_x`, then `rd_data_x = wb_data`. Otherwise `rd_data_x = regs[rd_addr_x]`.
- Issue is accepted when `issue_valid && !issue_stall`. On acceptance:
  - arith sets `pending[issue_dst]`;
  - cmp sets `fcc_pending`.
- Writeback clears `pending[wb_dst]` (arith) or `fcc_pending` (cmp). Writeback to a non-pending entry is legal and only writes data.
- Simultaneous set and clear of the same index or of `fcc_pending`: set wins (the issuing instruction is younger).
- Let `eff = pending & ~wb_clear_mask`. Then `issue_stall = issue_valid && (eff[rd_addr_a] || eff[rd_addr_b] || (arith && eff[issue_dst]))`.
- `issue_stall` is 0 when `issue_valid` is 0.
- `fcc_valid = !fcc_pending`.
- Reset: all `regs` = 0, `pending` = 0, `fcc_pending` = 0, `fcc` = 0. A write or issue in a reset cycle is discarded.

## Timing
- Reads: zero latency. Writeback data is visible the same cycle via bypass and from the array the next cycle.
- Scoreboard set is visible the cycle after acceptance. A same-cycle clear removes the stall immediately because of `eff`.
- `fcc` updates one cycle after the compare writeback. `fcc_valid` rises the same edge.
- Outputs after reset edge:
  - `rd_data_*` = 0, unless a bypass is active;
  - `fcc` = 0, `fcc_valid` = 1, `pending` = 0, `issue_stall` = 0.
- No internal backpressure on writeback: `wb_valid` is always accepted.

## Structure
- Shared package `fpu_pkg` holds:
  - op code constants `FP_ADD`, `FP_SUB`, `FP_CEQ`, `FP_CLT`, `FP_CGT`, `FP_CGE`, `FP_CLE`;
  - functions `is_arith(op)` and `is_cmp(op)`.
  The FPU uses the same package.
- One sub-module, `fp_scoreboard`, holds the `pending`/`fcc_pending` registers, the set/clear logic and stall generation. The top level holds the array, bypass muxes and `fcc`.

## Test plan
- Reset, then read all 32 addresses → all 0; `fcc` = 0, `fcc_valid` = 1, `pending` = 0.
- wb add: dst 5, data 0x40400000; same cycle `rd_addr_a` = 5 → `rd_data_a` = 0x40400000 (bypass). Next cycle, read 5 → 0x40400000.
- Issue add dst 3; next cycle, issue with `rd_addr_b` = 3 → `issue_stall` = 1. Then wb dst 3 data 0x3F800000 that cycle → `issue_stall` = 0, `rd_data_b` = 0x3F800000.
- Issue cmp op 9 → `fcc_valid` = 0. wb op 9 data 1 → next cycle `fcc` = 1, `fcc_valid` = 1, register file unchanged.
- Same cycle: wb dst 7 and accepted issue dst 7 → `pending[7]` = 1 afterwards.
- Issue op 0 → `pending` unchanged. wb op 0 → no write, `fcc` unchanged.
- Assert `rst` while `pending` = 0x0000_0088 and `wb_valid` = 1 → next cycle `pending` = 0, target register still 0.
